// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   state_e    : responder FSM states (IDLE, WAIT, RESP)
//   F3_*       : RV32 load/store func3 encodings
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_lane_unit.sv
// dmem_lane_unit: combinational byte-lane steering for one access.
//   we        in  1 = store, 0 = load (selects the legal func3 set)
//   func3     in  RV32 load/store size/sign encoding
//   addr      in  low two byte-address bits
//   wdata     in  store data, value in the low bits
//   rword     in  32-bit word read from storage
//   byte_en   out lanes written by a store
//   wword     out store data replicated across lanes
//   rdata_ext out selected, sign/zero-extended load data
//   err       out illegal func3 or misaligned address
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  func3,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    byte_en   = 4'b0000;
    wword     = 32'h0;
    rdata_ext = 32'h0;
    err       = 1'b0;
    rbyte     = 8'(rword >> {addr, 3'b000});
    rhalf     = 16'(rword >> {addr[1], 4'b0000});

    // Size decode from func3[1:0]; size 11 is never legal.
    case (func3[1:0])
      2'b00: begin
        byte_en = 4'b0001 << addr;
        wword   = {4{wdata[7:0]}};
      end
      2'b01: begin
        byte_en = addr[1] ? 4'b1100 : 4'b0011;
        wword   = {2{wdata[15:0]}};
        err     = addr[0];
      end
      2'b10: begin
        byte_en = 4'b1111;
        wword   = wdata;
        err     = (addr != 2'b00);
      end
      default: err = 1'b1;
    endcase

    // Stores have no unsigned forms; loads have no unsigned word (110).
    if (we) err = err | func3[2];
    else    err = err | (func3[2] & func3[1]);

    case (func3)
      F3_B:    rdata_ext = {{24{rbyte[7]}}, rbyte};
      F3_BU:   rdata_ext = {24'h0, rbyte};
      F3_H:    rdata_ext = {{16{rhalf[15]}}, rhalf};
      F3_HU:   rdata_ext = {16'h0, rhalf};
      F3_W:    rdata_ext = rword;
      default: rdata_ext = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the core load/store interface.
// Accepts one request (valid/ready), waits WAIT_CYCLES, performs the
// byte/half/word access on internal storage, returns data or error
// through a valid/ready response.
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we/addr/func3/wdata  request fields, latched on accept
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata, rsp_err    load result (0 for stores/errors), error flag
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 11,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_func3,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  // Storage is deliberately not reset; contents survive reset.
  logic [31:0] mem [DEPTH];

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            f3_q, f3_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic        idle, access, mem_we;
  logic        lu_we;
  logic [2:0]  lu_f3;
  logic [1:0]  lu_addr;
  logic [31:0] lu_wdata, rword;
  logic [3:0]  lu_byte_en;
  logic [31:0] lu_wword, lu_rdata;
  logic        lu_err;

  assign idle   = (state_q == IDLE);
  assign access = (state_q == WAIT) && (cnt_q == 4'd0);
  assign mem_we = access && we_q;
  assign rword  = mem[addr_q[ADDR_WIDTH-1:2]];

  // One lane unit serves both jobs: in IDLE it checks the incoming
  // request for errors, afterwards it steers the latched request.
  assign lu_we    = idle ? req_we          : we_q;
  assign lu_f3    = idle ? req_func3       : f3_q;
  assign lu_addr  = idle ? req_addr[1:0]   : addr_q[1:0];
  assign lu_wdata = idle ? req_wdata       : wdata_q;

  dmem_lane_unit u_lane (
    .we        (lu_we),
    .func3     (lu_f3),
    .addr      (lu_addr),
    .wdata     (lu_wdata),
    .rword     (rword),
    .byte_en   (lu_byte_en),
    .wword     (lu_wword),
    .rdata_ext (lu_rdata),
    .err       (lu_err)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    f3_d        = f3_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        addr_d  = req_addr;
        f3_d    = req_func3;
        wdata_d = req_wdata;
        if (lu_err) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0;
        end else begin
          state_d = WAIT;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = 4'(cnt_q - 4'd1);
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = we_q ? 32'h0 : lu_rdata;
        end
      end
      RESP: if (rsp_ready) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0;
        rsp_err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      f3_q        <= 3'b000;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      f3_q        <= f3_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // A reset landing on the access edge also drops the store.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lu_byte_en[i]) mem[addr_q[ADDR_WIDTH-1:2]][8*i +: 8] <= lu_wword[8*i +: 8];
      end
    end
  end

  assign req_ready = idle;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam int AW = 11;
  localparam int WC = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [2:0]    req_func3 = 3'b000;
  logic [31:0]   req_wdata = 32'h0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_func3(req_func3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;
  time t_acc;

  // Reference byte memory, modelled as a plain byte array.
  logic [7:0] mm [0:(1<<AW)-1];

  function automatic bit m_err(input bit we, input int a, input logic [2:0] f3);
    int sz;
    bit legal;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 1'b1;
    sz = 1 << f3[1:0];
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] m_load(input int a, input logic [2:0] f3);
    int sz;
    logic [31:0] v;
    sz = 1 << f3[1:0];
    v = 32'h0;
    for (int i = 0; i < sz; i++) v = v | (32'(mm[a+i]) << (8*i));
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
    return v;
  endfunction

  task automatic m_store(input int a, input logic [2:0] f3, input logic [31:0] wd);
    int sz;
    sz = 1 << f3[1:0];
    for (int i = 0; i < sz; i++) mm[a+i] = wd[8*i +: 8];
  endtask

  // Drives one request; lat = edges after accept before rsp_valid seen
  // (0 means the cycle right after accept), -1 on timeout.
  task automatic do_req(input bit we, input int a, input logic [2:0] f3, input logic [31:0] wd,
                        input bit hold, output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    rsp_ready = !hold;
    req_valid = 1'b1; req_we = we; req_addr = AW'(a); req_func3 = f3; req_wdata = wd;
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = AW'($urandom); req_func3 = 3'($urandom); req_wdata = $urandom;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) lat = -1;
    rd = rsp_rdata;
    er = rsp_err;
    if (!hold) @(posedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 11'h000; req_func3 = 3'b010; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); else n_pass++;
    n_checks++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err: got %b want 0", rsp_err); else n_pass++;
    reset = 1'b0;
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL reset_with_req: rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready); else n_pass++;
  endtask

  task automatic test_init();
    logic [31:0] rd; logic er; int lat; int bad;
    bad = 0;
    for (int a = 0; a < 256; a += 4) begin
      do_req(1'b1, a, 3'b010, 32'h0, 1'b0, rd, er, lat);
      m_store(a, 3'b010, 32'h0);
      if (rd !== 32'h0 || er !== 1'b0 || lat != WC + 1) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL init_stores: got %0d bad responses want 0", bad); else n_pass++;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 'h010, 3'b010, 32'hDEADBEEF, 1'b0, rd, er, lat);
    m_store('h010, 3'b010, 32'hDEADBEEF);
    n_checks++; if (rd !== 32'h0 || er !== 1'b0) $display("FAIL sw_rsp: got %h/%b want 0/0", rd, er); else n_pass++;
    do_req(1'b0, 'h010, 3'b010, 32'h0, 1'b0, rd, er, lat);
    n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL lw_data: got %h want deadbeef", rd); else n_pass++;
    n_checks++; if (er !== 1'b0) $display("FAIL lw_err: got %b want 0", er); else n_pass++;
    n_checks++; if (lat != WC + 1) $display("FAIL lw_latency: got %0d want %0d", lat, WC + 1); else n_pass++;
  endtask

  task automatic test_bytes();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 'h023, 3'b000, 32'h1A5, 1'b0, rd, er, lat);
    m_store('h023, 3'b000, 32'h1A5);
    do_req(1'b0, 'h020, 3'b010, 32'h0, 1'b0, rd, er, lat);
    n_checks++; if (rd !== 32'hA5000000) $display("FAIL sb_lw: got %h want a5000000", rd); else n_pass++;
    do_req(1'b0, 'h023, 3'b000, 32'h0, 1'b0, rd, er, lat);
    n_checks++; if (rd !== 32'hFFFFFFA5) $display("FAIL lb: got %h want ffffffa5", rd); else n_pass++;
    do_req(1'b0, 'h023, 3'b100, 32'h0, 1'b0, rd, er, lat);
    n_checks++; if (rd !== 32'h000000A5) $display("FAIL lbu: got %h want 000000a5", rd); else n_pass++;
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 'h030, 3'b010, 32'h0000BEEF, 1'b0, rd, er, lat);
    m_store('h030, 3'b010, 32'h0000BEEF);
    do_req(1'b1, 'h032, 3'b001, 32'h8001, 1'b0, rd, er, lat);
    m_store('h032, 3'b001, 32'h8001);
    do_req(1'b0, 'h032, 3'b001, 32'h0, 1'b0, rd, er, lat);
    n_checks++; if (rd !== 32'hFFFF8001) $display("FAIL lh: got %h want ffff8001", rd); else n_pass++;
    do_req(1'b0, 'h032, 3'b101, 32'h0, 1'b0, rd, er, lat);
    n_checks++; if (rd !== 32'h00008001) $display("FAIL lhu: got %h want 00008001", rd); else n_pass++;
    do_req(1'b0, 'h030, 3'b010, 32'h0, 1'b0, rd, er, lat);
    n_checks++; if (rd !== 32'h8001BEEF) $display("FAIL sh_lower_half: got %h want 8001beef", rd); else n_pass++;
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 'h041, 3'b010, 32'h0, 1'b0, rd, er, lat);
    n_checks++; if (lat != 0) $display("FAIL err_latency: got %0d want 0", lat); else n_pass++;
    n_checks++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL lw_misaligned: got %h/%b want 0/1", rd, er); else n_pass++;
    do_req(1'b1, 'h040, 3'b010, 32'h55667788, 1'b0, rd, er, lat);
    m_store('h040, 3'b010, 32'h55667788);
    do_req(1'b1, 'h043, 3'b001, 32'hFFFF, 1'b0, rd, er, lat);
    n_checks++; if (er !== 1'b1) $display("FAIL sh_misaligned: got %b want 1", er); else n_pass++;
    do_req(1'b0, 'h040, 3'b010, 32'h0, 1'b0, rd, er, lat);
    n_checks++; if (rd !== 32'h55667788) $display("FAIL err_store_untouched: got %h want 55667788", rd); else n_pass++;
    do_req(1'b0, 'h040, 3'b011, 32'h0, 1'b0, rd, er, lat);
    n_checks++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL f3_011_load: got %h/%b want 0/1", rd, er); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat; time t1;
    do_req(1'b0, 'h010, 3'b010, 32'h0, 1'b0, rd, er, lat);
    t1 = t_acc;
    do_req(1'b0, 'h020, 3'b010, 32'h0, 1'b0, rd, er, lat);
    n_checks++; if ((t_acc - t1) / 10 != WC + 3)
      $display("FAIL back_to_back_gap: got %0d want %0d", (t_acc - t1) / 10, WC + 3); else n_pass++;
    n_checks++; if (rd !== m_load('h020, 3'b010)) $display("FAIL back_to_back_data: got %h want %h", rd, m_load('h020, 3'b010)); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; int bad;
    do_req(1'b0, 'h010, 3'b010, 32'h0, 1'b1, rd, er, lat);
    n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL bp_data: got %h want deadbeef", rd); else n_pass++;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 11'h060; req_func3 = 3'b010; req_wdata = 32'hAAAAAAAA;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); else n_pass++;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0)
      $display("FAIL bp_release: valid=%b ready=%b rdata=%h want 0/1/0", rsp_valid, req_ready, rsp_rdata); else n_pass++;
    req_valid = 1'b0;
    do_req(1'b0, 'h060, 3'b010, 32'h0, 1'b0, rd, er, lat);
    n_checks++; if (rd !== m_load('h060, 3'b010)) $display("FAIL bp_ignored_store: got %h want %h", rd, m_load('h060, 3'b010)); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; int bad;
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 11'h050; req_func3 = 3'b010; req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0)
      $display("FAIL reset_mid_outputs: ready=%b valid=%b rdata=%h err=%b want 1/0/0/0", req_ready, rsp_valid, rsp_rdata, rsp_err); else n_pass++;
    reset = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL reset_mid_no_rsp: got %0d valid cycles want 0", bad); else n_pass++;
    do_req(1'b0, 'h050, 3'b010, 32'h0, 1'b0, rd, er, lat);
    n_checks++; if (rd !== 32'h0) $display("FAIL reset_mid_dropped: got %h want 0", rd); else n_pass++;
    // Store already committed, response pending when reset hits.
    do_req(1'b1, 'h054, 3'b010, 32'hCAFEF00D, 1'b1, rd, er, lat);
    m_store('h054, 3'b010, 32'hCAFEF00D);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_resp_discard: got %b want 0", rsp_valid); else n_pass++;
    do_req(1'b0, 'h054, 3'b010, 32'h0, 1'b0, rd, er, lat);
    n_checks++; if (rd !== 32'hCAFEF00D) $display("FAIL reset_committed: got %h want cafef00d", rd); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] rd, wd, exp_rd; logic er; int lat, a; bit we, exp_er; logic [2:0] f3;
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom_range(0, 252);
      wd = $urandom;
      exp_er = m_err(we, a, f3);
      exp_rd = (we || exp_er) ? 32'h0 : m_load(a, f3);
      do_req(we, a, f3, wd, 1'b0, rd, er, lat);
      if (we && !exp_er) m_store(a, f3, wd);
      n_checks++; if (er !== exp_er) $display("FAIL rand_err[%0d]: got %b want %b (we=%b a=%h f3=%b)", n, er, exp_er, we, a, f3); else n_pass++;
      n_checks++; if (rd !== exp_rd) $display("FAIL rand_rdata[%0d]: got %h want %h (we=%b a=%h f3=%b)", n, rd, exp_rd, we, a, f3); else n_pass++;
      n_checks++; if (lat != (exp_er ? 0 : WC + 1)) $display("FAIL rand_latency[%0d]: got %0d want %0d", n, lat, exp_er ? 0 : WC + 1); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_word();
    test_bytes();
    test_half();
    test_errors();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
